// File: rtl/linear_network_multicast_pipe_pkg.sv
// Shared sizing helpers for linear network topologies: segment count and
// the node range covered by each pipeline segment.
package linear_network_multicast_pipe_pkg;

  function automatic int ceil_div(input int num, input int den);
    return (num + den - 1) / den;
  endfunction

  function automatic int seg_lo(input int seg, input int interval);
    return seg * interval;
  endfunction

  // The last segment is clipped to the final node when the chain length
  // is not a multiple of the interval.
  function automatic int seg_hi(input int seg, input int interval, input int num_node);
    return (seg * interval + interval - 1 < num_node) ? seg * interval + interval - 1
                                                      : num_node - 1;
  endfunction

endpackage

// File: rtl/linear_multicast_segment.sv
// One pipeline register stage of the multicast chain plus its node taps.
// Command bits for this segment's nodes are consumed; the rest travel on.
module linear_multicast_segment #(
  parameter  int DATA_WIDTH    = 32,
  parameter  int SEG_NODES     = 1,
  parameter  int IN_CMD_WIDTH  = 8,
  localparam int OUT_CMD_WIDTH = (IN_CMD_WIDTH > SEG_NODES) ? IN_CMD_WIDTH - SEG_NODES : 1
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            i_en,
  input  logic                            i_valid,
  input  logic [DATA_WIDTH-1:0]           i_data_bus,
  input  logic [IN_CMD_WIDTH-1:0]         i_cmd,
  output logic                            o_valid,
  output logic [DATA_WIDTH-1:0]           o_data_bus,
  output logic [OUT_CMD_WIDTH-1:0]        o_cmd,
  output logic                            o_live,
  output logic [SEG_NODES-1:0]            o_tap_valid,
  output logic [SEG_NODES*DATA_WIDTH-1:0] o_tap_data_bus
);

  logic                    valid_q;
  logic [DATA_WIDTH-1:0]   data_q;
  logic [IN_CMD_WIDTH-1:0] cmd_q;

  // A packet with no destinations left is dropped here rather than carried on.
  // NOTE: sequential state uses non-blocking assignments so every stage samples
  // its neighbour's pre-edge value and the chain shifts by exactly one stage.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      cmd_q   <= '0;
    end else if (i_en) begin
      valid_q <= i_valid & (|i_cmd);
      data_q  <= i_data_bus;
      cmd_q   <= i_cmd;
    end
  end

  assign o_live         = valid_q;
  assign o_data_bus     = data_q;
  assign o_tap_valid    = {SEG_NODES{valid_q & i_en}} & cmd_q[SEG_NODES-1:0];
  assign o_tap_data_bus = {SEG_NODES{data_q}};

  if (IN_CMD_WIDTH > SEG_NODES) begin : g_pass
    assign o_valid = valid_q;
    assign o_cmd   = cmd_q[IN_CMD_WIDTH-1:SEG_NODES];
  end else begin : g_tail
    assign o_valid = 1'b0;
    assign o_cmd   = '0;
  end

endmodule

// File: rtl/linear_network_multicast_pipe.sv
// Pipelined linear multicast chain: packets walk NUM_NODE taps with a register
// stage every REG_INTERVAL nodes, plus global stall, busy flag and delivery counters.
module linear_network_multicast_pipe
  import linear_network_multicast_pipe_pkg::*;
#(
  parameter int DATA_WIDTH   = 32,
  parameter int NUM_NODE     = 8,
  parameter int REG_INTERVAL = 1,
  parameter int CNT_WIDTH    = 16
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           i_valid,
  input  logic [DATA_WIDTH-1:0]          i_data_bus,
  input  logic [NUM_NODE-1:0]            i_cmd,
  input  logic                           i_en,
  output logic                           o_ready,
  output logic [NUM_NODE-1:0]            o_valid,
  output logic [NUM_NODE*DATA_WIDTH-1:0] o_data_bus,
  output logic                           o_busy,
  output logic [NUM_NODE*CNT_WIDTH-1:0]  o_cnt,
  input  logic                           i_cnt_clr
);

  localparam int NUM_SEG = ceil_div(NUM_NODE, REG_INTERVAL);

  // Chain index s feeds segment s; commands are kept at absolute node positions.
  logic [NUM_SEG:0]        chain_valid;
  logic [DATA_WIDTH-1:0]   chain_data [NUM_SEG+1];
  logic [NUM_NODE-1:0]     chain_cmd  [NUM_SEG+1];
  logic [NUM_SEG-1:0]      seg_live;
  logic [CNT_WIDTH-1:0]    cnt_q      [NUM_NODE];

  assign chain_valid[0] = i_valid;
  assign chain_data[0]  = i_data_bus;
  assign chain_cmd[0]   = i_cmd;

  for (genvar s = 0; s < NUM_SEG; s++) begin : g_seg
    localparam int LO    = seg_lo(s, REG_INTERVAL);
    localparam int NODES = seg_hi(s, REG_INTERVAL, NUM_NODE) - LO + 1;
    localparam int IN_W  = NUM_NODE - LO;
    localparam int OUT_W = (IN_W > NODES) ? IN_W - NODES : 1;

    logic [OUT_W-1:0] nxt_cmd;

    linear_multicast_segment #(
      .DATA_WIDTH   (DATA_WIDTH),
      .SEG_NODES    (NODES),
      .IN_CMD_WIDTH (IN_W)
    ) u_seg (
      .clk            (clk),
      .rst            (rst),
      .i_en           (i_en),
      .i_valid        (chain_valid[s]),
      .i_data_bus     (chain_data[s]),
      .i_cmd          (chain_cmd[s][NUM_NODE-1:LO]),
      .o_valid        (chain_valid[s+1]),
      .o_data_bus     (chain_data[s+1]),
      .o_cmd          (nxt_cmd),
      .o_live         (seg_live[s]),
      .o_tap_valid    (o_valid[LO +: NODES]),
      .o_tap_data_bus (o_data_bus[LO*DATA_WIDTH +: NODES*DATA_WIDTH])
    );

    if (IN_W > NODES) begin : g_fwd
      assign chain_cmd[s+1] = {nxt_cmd, {(LO + NODES){1'b0}}};
    end else begin : g_end
      assign chain_cmd[s+1] = '0;
    end
  end

  assign o_ready = i_en & ~rst;
  assign o_busy  = |seg_live;

  // o_valid already folds in i_en, so a stalled delivery is counted only once,
  // on the edge where it is actually signalled.
  // NOTE: the counter array is a bank of flops, not a RAM, so it is reset like any
  // other state; a RAM-style array would be left unreset.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < NUM_NODE; k++) cnt_q[k] <= '0;
    end else begin
      for (int k = 0; k < NUM_NODE; k++) begin
        if (i_cnt_clr)       cnt_q[k] <= '0;
        else if (o_valid[k]) cnt_q[k] <= cnt_q[k] + 1'b1;
      end
    end
  end

  for (genvar k = 0; k < NUM_NODE; k++) begin : g_cnt
    assign o_cnt[k*CNT_WIDTH +: CNT_WIDTH] = cnt_q[k];
  end

endmodule

// File: tb/tb_linear_network_multicast_pipe.sv
// Self-checking bench: two chain configurations (RI=1/CNT=16 and RI=3/CNT=2)
// share one stimulus stream; a delivery scoreboard predicts every tap event.
module tb_linear_network_multicast_pipe;

  logic        clk = 1'b0;
  logic        rst, i_valid, i_en, i_cnt_clr;
  logic [7:0]  i_data_bus, i_cmd;

  logic        o_ready_a, o_busy_a, o_ready_b, o_busy_b;
  logic [7:0]  o_valid_a, o_valid_b;
  logic [63:0] o_data_a, o_data_b;
  logic [127:0] o_cnt_a;
  logic [15:0] o_cnt_b;

  typedef struct {
    int         dut;
    int         node;
    int         due;
    logic [7:0] data;
  } exp_t;

  exp_t        sb[$];
  int          adv;
  int          checks;
  int          errors;
  logic [15:0] mcnt [2][8];
  bit          dlv  [2][8];

  always #5 clk = ~clk;

  linear_network_multicast_pipe #(
    .DATA_WIDTH(8), .NUM_NODE(8), .REG_INTERVAL(1), .CNT_WIDTH(16)
  ) dut_a (
    .clk(clk), .rst(rst), .i_valid(i_valid), .i_data_bus(i_data_bus), .i_cmd(i_cmd),
    .i_en(i_en), .o_ready(o_ready_a), .o_valid(o_valid_a), .o_data_bus(o_data_a),
    .o_busy(o_busy_a), .o_cnt(o_cnt_a), .i_cnt_clr(i_cnt_clr)
  );

  linear_network_multicast_pipe #(
    .DATA_WIDTH(8), .NUM_NODE(8), .REG_INTERVAL(3), .CNT_WIDTH(2)
  ) dut_b (
    .clk(clk), .rst(rst), .i_valid(i_valid), .i_data_bus(i_data_bus), .i_cmd(i_cmd),
    .i_en(i_en), .o_ready(o_ready_b), .o_valid(o_valid_b), .o_data_bus(o_data_b),
    .o_busy(o_busy_b), .o_cnt(o_cnt_b), .i_cnt_clr(i_cnt_clr)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] cnt_mask(input int d);
    return (d == 0) ? 16'hFFFF : 16'h0003;
  endfunction

  task automatic check_dut(input int d, input logic [7:0] ov, input logic [63:0] od,
                           input logic busy, input logic [127:0] cnt, input int cw);
    bit live;
    int idx;
    live = 1'b0;
    foreach (sb[i]) if (sb[i].dut == d && sb[i].due >= adv) live = 1'b1;
    chk($sformatf("busy d%0d", d), {63'd0, busy}, {63'd0, live});
    for (int k = 0; k < 8; k++) begin
      dlv[d][k] = 1'b0;
      cnt_check: begin
        logic [127:0] sh;
        sh = cnt >> (k * cw);
        chk($sformatf("cnt d%0d n%0d", d, k), {48'd0, sh[15:0] & cnt_mask(d)},
            {48'd0, mcnt[d][k]});
      end
      if (!rst) begin
        idx = -1;
        if (i_en)
          foreach (sb[i]) if (sb[i].dut == d && sb[i].node == k && sb[i].due == adv) idx = i;
        dlv[d][k] = (idx >= 0);
        chk($sformatf("valid d%0d n%0d", d, k), {63'd0, ov[k]}, {63'd0, dlv[d][k]});
        if (idx >= 0) begin
          chk($sformatf("data d%0d n%0d", d, k), {56'd0, od[k*8 +: 8]}, {56'd0, sb[idx].data});
          sb.delete(idx);
        end
      end
    end
  endtask

  task automatic step(input logic v, input logic [7:0] dt, input logic [7:0] cm,
                      input logic en, input logic clr, input logic r);
    i_valid = v; i_data_bus = dt; i_cmd = cm; i_en = en; i_cnt_clr = clr; rst = r;
    #1;
    chk("ready a", {63'd0, o_ready_a}, {63'd0, en & ~r});
    chk("ready b", {63'd0, o_ready_b}, {63'd0, en & ~r});
    check_dut(0, o_valid_a, o_data_a, o_busy_a, o_cnt_a, 16);
    check_dut(1, o_valid_b, o_data_b, o_busy_b, {112'd0, o_cnt_b}, 2);
    @(posedge clk);
    if (r) begin
      sb.delete();
      for (int d = 0; d < 2; d++) for (int k = 0; k < 8; k++) mcnt[d][k] = '0;
    end else begin
      for (int d = 0; d < 2; d++)
        for (int k = 0; k < 8; k++)
          if (clr)          mcnt[d][k] = '0;
          else if (dlv[d][k]) mcnt[d][k] = (mcnt[d][k] + 16'd1) & cnt_mask(d);
      if (en) begin
        adv++;
        if (v && cm != 8'd0)
          for (int d = 0; d < 2; d++)
            for (int k = 0; k < 8; k++)
              if (cm[k]) sb.push_back('{dut: d, node: k, due: adv + k / (d == 0 ? 1 : 3), data: dt});
      end
    end
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic send(input logic [7:0] dt, input logic [7:0] cm);
    step(1'b1, dt, cm, 1'b1, 1'b0, 1'b0);
  endtask

  initial begin
    checks = 0; errors = 0; adv = 0;
    for (int d = 0; d < 2; d++) for (int k = 0; k < 8; k++) begin
      mcnt[d][k] = '0; dlv[d][k] = 1'b0;
    end
    rst = 1'b1; i_valid = 1'b0; i_en = 1'b0; i_cnt_clr = 1'b0; i_data_bus = '0; i_cmd = '0;
    @(negedge clk);
    step(1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b1);
    step(1'b1, 8'hEE, 8'hFF, 1'b1, 1'b0, 1'b1);
    chk("reset data a", o_data_a, 64'd0);
    chk("reset valid b", {56'd0, o_valid_b}, 64'd0);

    // Unicast to node 0, then full multicast and the 0/7 pair.
    send(8'hA5, 8'h01);
    idle(3);
    send(8'h11, 8'hFF);
    idle(9);
    send(8'h22, 8'h81);
    idle(9);

    // Back-to-back stream stalled mid-flight for two cycles.
    send(8'h31, 8'hFF);
    send(8'h32, 8'h3C);
    send(8'h33, 8'hF0);
    idle(1);
    step(1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
    step(1'b1, 8'h77, 8'hFF, 1'b0, 1'b0, 1'b0);
    idle(10);

    // Empty command is dropped; reset kills an in-flight packet.
    send(8'h44, 8'h00);
    idle(2);
    send(8'h55, 8'hFF);
    idle(1);
    step(1'b0, 8'h00, 8'h00, 1'b1, 1'b1, 1'b1);
    idle(10);

    // Five deliveries to node 3: the 2-bit counter wraps to 1.
    for (int i = 0; i < 5; i++) send(8'h60 + 8'(i), 8'h08);
    idle(6);
    chk("wrap b n3", {62'd0, o_cnt_b[7:6]}, 64'd1);
    chk("count a n3", {48'd0, o_cnt_a[63:48]}, 64'd5);

    // Clear coincident with a delivery wins.
    send(8'h66, 8'h08);
    for (int i = 0; i < 4; i++) step(1'b0, 8'h00, 8'h00, 1'b1, 1'b1, 1'b0);
    chk("clr b n3", {62'd0, o_cnt_b[7:6]}, 64'd0);
    chk("clr a n3", {48'd0, o_cnt_a[63:48]}, 64'd0);

    // Mixed traffic with occasional stalls and clears.
    for (int i = 0; i < 60; i++)
      step(1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom),
           ($urandom_range(0, 3) != 0), ($urandom_range(0, 15) == 0), 1'b0);
    idle(12);
    chk("scoreboard empty", 64'(sb.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
